// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation encodings, state type and datapath width.
package muldiv_pkg;

    localparam int unsigned MD_XLEN = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} md_state_t;

    // True for the four iterative operations (MULT/MULTU/DIV/DIVU).
    function automatic logic md_is_iter(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute-stage control and the mul/div unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            abort;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (output start, op, a, b, abort, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, abort, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared shift datapath:
// right-shifting shift-add multiply, or left-shifting restoring divide.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] sh_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] sh_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i} + (sh_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i, sh_i[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        if (is_div_i) begin
            // Partial remainder stays below the divisor, so diff's top bit is a clean borrow.
            if (!diff[XLEN]) begin
                acc_o = diff[XLEN-1:0];
                sh_o  = {sh_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[XLEN-1:0];
                sh_o  = {sh_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[XLEN:1];
            sh_o  = {sum[0], sh_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write directly.
// Operands are latched at accept, made unsigned in PREP, iterated in CALC, sign-fixed in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

    md_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic [XLEN-1:0] acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;
    logic [2:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            is_div, signed_op;
    logic [XLEN-1:0] abs_a, abs_b, step_acc, step_sh;
    logic [2*XLEN-1:0] prod;

    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign signed_op = (op_q == MD_DIV) || (op_q == MD_MULT);
    assign abs_a     = (signed_op && a_raw_q[XLEN-1]) ? -a_raw_q : a_raw_q;
    assign abs_b     = (signed_op && b_raw_q[XLEN-1]) ? -b_raw_q : b_raw_q;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div),
        .acc_i    (acc_q),
        .sh_i     (sh_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .sh_o     (step_sh)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        prod      = {acc_q, sh_q};
        unique case (state_q)
            IDLE: begin
                if (bus_io.start && !bus_io.abort) begin
                    if (md_is_iter(bus_io.op)) begin
                        state_d = PREP;
                        op_d    = bus_io.op;
                        a_raw_d = bus_io.a;
                        b_raw_d = bus_io.b;
                    end else if (bus_io.op == MD_MTHI) begin
                        hi_d = bus_io.a;
                    end else if (bus_io.op == MD_MTLO) begin
                        lo_d = bus_io.a;
                    end
                end
            end
            PREP: begin
                state_d   = CALC;
                cnt_d     = '0;
                acc_d     = '0;
                sh_d      = is_div ? abs_a : abs_b;
                opnd_d    = is_div ? abs_b : abs_a;
                neg_res_d = signed_op && (a_raw_q[XLEN-1] ^ b_raw_q[XLEN-1]);
                neg_rem_d = signed_op && a_raw_q[XLEN-1];
                div0_d    = is_div && (b_raw_q == '0);
            end
            CALC: begin
                acc_d = step_acc;
                sh_d  = step_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div0_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else if (!is_div) begin
                    if (neg_res_q) prod = -prod;
                    hi_d = prod[2*XLEN-1:XLEN];
                    lo_d = prod[XLEN-1:0];
                end else begin
                    lo_d = neg_res_q ? -sh_q : sh_q;
                    hi_d = neg_rem_q ? -acc_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything, including a FIX-cycle write.
        if (bus_io.abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            opnd_q    <= '0;
            op_q      <= MD_MULT;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.busy = busy_q;
    assign bus_io.done = done_q;
    assign bus_io.hi   = hi_q;
    assign bus_io.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model compared on every cycle,
// directed cases with literal results, then randomized traffic with aborts.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   nchk = 0;
    int   npass = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                                input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        res = '0;
        case (o)
            MD_MULT:  res = 64'(sx * sy);
            MD_MULTU: res = {32'b0, x} * {32'b0, y};
            MD_DIV: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Timing model: an accepted mul/div keeps the unit busy for 34 cycles.
    int          m_rem;
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    logic [63:0] m_pend;
    logic        m_busy;
    assign m_busy = (m_rem != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
        end else if (bus.abort) begin
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                if (bus.op <= MD_DIVU) begin
                    m_pend <= ref_result(bus.op, bus.a, bus.b);
                    m_rem  <= 34;
                end else if (bus.op == MD_MTHI) m_hi <= bus.a;
                else if (bus.op == MD_MTLO) m_lo <= bus.a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
            check("done", {31'b0, bus.done}, {31'b0, m_done});
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    // Caller sits at a negedge; request is held across exactly one rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        issue(o, x, y);
        @(negedge clk);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(n), 32'd34);
        check({name, "_done"}, {31'b0, bus.done}, 32'd1);
        check({name, "_hi"}, bus.hi, exp_hi);
        check({name, "_lo"}, bus.lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            4: v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int seen;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        @(negedge clk);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        @(negedge clk);
        check("done_one_pulse", {31'b0, bus.done}, 32'd0);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF);
        run_op("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div_zero_s", MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // MTHI then MTLO on consecutive edges.
        bus.start = 1'b1; bus.op = MD_MTHI; bus.a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 bus.op = MD_MTLO; bus.a = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234_5678);
        check("mtlo_done", {31'b0, bus.done}, 32'd0);

        // Undefined op is ignored.
        issue(3'd6, 32'hAAAA_AAAA, 32'd1);
        @(negedge clk);
        check("undef_busy", {31'b0, bus.busy}, 32'd0);
        check("undef_hi", bus.hi, 32'hDEAD_BEEF);

        // Ignored start mid-op, then abort.
        issue(MD_DIVU, 32'd1000, 32'd7);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = (i == 10);
            bus.op    = MD_MTLO;
            bus.a     = 32'hBAD0_BAD0;
            bus.abort = (i == 20);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'hDEAD_BEEF);
        check("abort_lo", bus.lo, 32'h1234_5678);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Abort together with start from idle drops the request.
        bus.abort = 1'b1;
        issue(MD_MTHI, 32'h5555_5555, 32'd0);
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_start_hi", bus.hi, 32'hDEAD_BEEF);

        // Asynchronous reset mid-CALC.
        issue(MD_DIVU, 32'd5, 32'd3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_hi", bus.hi, 32'h0);
        check("rst_mid_lo", bus.lo, 32'h0);
        check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: second op accepted in the first idle cycle.
        run_op("divu_prior", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("b2b_multu", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        // Randomized traffic; the per-cycle compare against the model does the checking.
        for (int c = 0; c < 4000; c++) begin
            bus.start = ($urandom_range(0, 5) == 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.a     = pick();
            bus.b     = pick();
            bus.abort = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide sequencer that owns the HI/LO registers. It sits beside the ALU in the execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. The pipeline control unit uses `busy` to stall MFHI/MFLO and any new mul/div while an operation is in flight. A single 32-iteration shift datapath is shared by multiply (shift-add) and divide (restoring).

Parameters:
XLEN, 32, operand/HI/LO width; iteration count equals XLEN.

Ports:
clk     in   1     clock, rising edge
reset   in   1     asynchronous, active-high; clears all state
start   in   1     request; accepted only when busy=0
op      in   3     operation code, from muldiv_pkg
a       in   XLEN  rs operand (dividend / multiplicand / MTHI-MTLO data)
b       in   XLEN  rt operand (divisor / multiplier)
abort   in   1     exception flush; cancels an in-flight op
busy    out  1     operation in flight (state != IDLE), registered
done    out  1     one-cycle pulse in the cycle after HI/LO are written by a mul/div
hi      out  XLEN  HI register
lo      out  XLEN  LO register

Behaviour:
- Reset (asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- States:
  - IDLE: accept a request at an edge where start=1 and busy=0.
  - PREP: 1 cycle. Latch |a| and |b| for signed ops, raw values for unsigned ops. Record result-sign flags. Detect b==0.
  - CALC: exactly 32 cycles. Counter runs 0..31; exit to FIX when the counter reaches 31.
  - FIX: 1 cycle. Apply sign correction, write hi/lo, return to IDLE, set done for the next cycle.
- Timing for mul/div accepted at edge E0:
  - busy is high for exactly 34 cycles (E0+1 .. E0+34).
  - New hi/lo are visible in the first cycle with busy=0, coincident with done=1.
- MTHI/MTLO:
  - No state change.
  - hi (MTHI) or lo (MTLO) is written with `a` at the accepting edge.
  - busy and done stay 0.
- Undefined op codes (6, 7): ignored; no state change.
- start while busy=1: ignored, regardless of op. hi/lo are not touched mid-operation.
- Multiply:
  - Forms the 64-bit product {hi,lo}.
  - MULT: if sign(a) XOR sign(b), the 64-bit two's-complement negation is applied in FIX.
- Divide:
  - lo = quotient, hi = remainder.
  - DIV: quotient is negated if sign(a) XOR sign(b); remainder takes the sign of a (truncating division).
  - Divide by zero, DIV and DIVU alike: lo=32'hFFFF_FFFF, hi=a (original, unmodified), sign fix bypassed. Iterations still run; latency is unchanged.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural mod-2^32 wrap, no trap).
- abort:
  - Returns to IDLE at the next edge from any state; hi/lo are unchanged; done stays 0.
  - Abort and start in the same cycle with busy=0: abort wins and the request is dropped.
- reset mid-operation: immediate IDLE, hi=lo=0.
- No overflow output; mul/div never trap.

Decomposition:
- muldiv_pkg holds:
  - op encoding: MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5;
  - state enum md_state_t {IDLE, PREP, CALC, FIX}.
- One sub-module is natural: muldiv_step. It is a combinational single iteration: shift-add for multiply, compare/subtract/shift for divide, selected by an is_div input. This keeps the FSM/counter/sign logic separate in muldiv_unit.

Test Plan:
1. MULTU a=FFFF_FFFF, b=FFFF_FFFF -> busy high for 34 cycles; then hi=FFFF_FFFE, lo=0000_0001, done pulses once.
2. MULT a=FFFF_FFFD (-3), b=7 -> hi=FFFF_FFFF, lo=FFFF_FFEB. DIV a=FFFF_FFF9 (-7), b=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF.
3. DIVU a=100, b=0 -> lo=FFFF_FFFF, hi=0000_0064 after 34 busy cycles. DIV a=8000_0000, b=FFFF_FFFF -> lo=8000_0000, hi=0.
4. MTHI a=DEAD_BEEF then MTLO a=1234_5678 on consecutive cycles -> hi/lo update on each accepting edge; busy never asserts.
5. Start DIVU; pulse start with MTLO at cycle 10 (ignored); pulse abort at cycle 20 -> busy drops next cycle, hi/lo keep pre-op values, no done. Assert reset mid-CALC of a second op -> hi=lo=0 immediately.
6. Back-to-back: MULTU 6×7 accepted in the first busy=0 cycle after a prior DIVU -> hi=0, lo=42 exactly 34 cycles later.
